// File: rtl/ann_pkg.sv
// Shared definitions for the layer pipeline blocks: collector state encoding,
// accumulator width helper and signed saturation limits.
package ann_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PROC,
        HOLD
    } state_t;

    // Raw neuron accumulators carry 8 guard bits above the layer data width.
    function automatic int ACC_W(input int w);
        return w + 8;
    endfunction

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/layer_output_collector_requant_sat.sv
// requant_sat: combinational arithmetic right shift followed by signed
// saturation from IN_W to OUT_W bits, with a flag when clamping occurs.
module requant_sat
    import ann_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 2
) (
    input  logic [IN_W-1:0]  value_in,
    output logic [OUT_W-1:0] value_out,
    output logic             sat
);

    localparam logic signed [63:0]     MAX64 = sat_max(OUT_W);
    localparam logic signed [63:0]     MIN64 = sat_min(OUT_W);
    localparam logic signed [IN_W-1:0] MAX_V = MAX64[IN_W-1:0];
    localparam logic signed [IN_W-1:0] MIN_V = MIN64[IN_W-1:0];

    logic signed [IN_W-1:0] shifted;

    // Floor toward minus infinity comes for free from the arithmetic shift.
    always_comb begin
        shifted   = $signed(value_in) >>> SHIFT;
        value_out = shifted[OUT_W-1:0];
        sat       = 1'b0;
        if (shifted > MAX_V) begin
            value_out = MAX_V[OUT_W-1:0];
            sat       = 1'b1;
        end else if (shifted < MIN_V) begin
            value_out = MIN_V[OUT_W-1:0];
            sat       = 1'b1;
        end
    end

endmodule

// File: rtl/layer_output_collector.sv
// Collects one raw neuron vector, requantizes it serially through a shared
// requant_sat and presents it downstream. Define ARGMAX_EN to add argmax_idx.
module layer_output_collector
    import ann_pkg::*;
#(
    parameter int LAYER_DATA_WIDTH = 8,
    parameter int NUM_NEURONS      = 4,
    parameter int SHIFT            = 2
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [NUM_NEURONS*ACC_W(LAYER_DATA_WIDTH)-1:0]    neuron_in,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [NUM_NEURONS*LAYER_DATA_WIDTH-1:0]           data_out,
    output logic                                              sat_flag
`ifdef ARGMAX_EN
    ,
    output logic [$clog2(NUM_NEURONS)-1:0]                    argmax_idx
`endif
);

    localparam int W     = LAYER_DATA_WIDTH;
    localparam int AW    = ACC_W(LAYER_DATA_WIDTH);
    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [AW-1:0]    in_buf  [NUM_NEURONS];
    logic [W-1:0]     out_reg [NUM_NEURONS];
    logic [W-1:0]     rq_value;
    logic             rq_sat;
    logic             accept;
    logic             last;

    // A HOLD handoff with in_valid high reloads in the same cycle.
    assign in_ready  = rst_n && ((state == IDLE) || ((state == HOLD) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == HOLD);
    assign last      = (idx == LAST_IDX);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_valid) state_next = PROC;
            PROC: if (last) state_next = HOLD;
            HOLD: if (out_ready) state_next = in_valid ? PROC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                in_buf[i] <= neuron_in[i*AW +: AW];
            end
        end
    end

    requant_sat #(
        .IN_W  (AW),
        .OUT_W (W),
        .SHIFT (SHIFT)
    ) u_requant (
        .value_in  (in_buf[idx]),
        .value_out (rq_value),
        .sat       (rq_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            sat_flag <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                out_reg[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (accept) begin
                idx      <= '0;
                sat_flag <= 1'b0;
            end else if (state == PROC) begin
                out_reg[idx] <= rq_value;
                sat_flag     <= sat_flag | rq_sat;
                idx          <= last ? '0 : idx + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_pack
        assign data_out[g*W +: W] = out_reg[g];
    end

`ifdef ARGMAX_EN
    logic [W-1:0]     max_val;
    logic [IDX_W-1:0] max_idx;

    // Strictly-greater replacement keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_val <= '0;
            max_idx <= '0;
        end else if (state == PROC) begin
            if ((idx == '0) || ($signed(rq_value) > $signed(max_val))) begin
                max_val <= rq_value;
                max_idx <= idx;
            end
        end
    end

    assign argmax_idx = max_idx;
`endif

endmodule

// File: tb/tb_layer_output_collector.sv
// Scoreboard bench for layer_output_collector: directed vectors, backpressure,
// back-to-back, reset mid-PROC and randomized traffic. Honors ARGMAX_EN.
module tb_layer_output_collector;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SH = 2;
    localparam int AW = W + 8;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

    typedef struct {
        logic [N*W-1:0] data;
        logic           sat;
        int             amax;
        int             acc_cycle;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*AW-1:0] neuron_in = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [N*W-1:0]  data_out;
    logic            sat_flag;
`ifdef ARGMAX_EN
    logic [$clog2(N)-1:0] argmax_idx;
`endif

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   ready_mode = 2;
    logic ready_force = 1'b0;

    layer_output_collector #(
        .LAYER_DATA_WIDTH (W),
        .NUM_NEURONS      (N),
        .SHIFT            (SH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .neuron_in  (neuron_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .sat_flag   (sat_flag)
`ifdef ARGMAX_EN
        ,
        .argmax_idx (argmax_idx)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Reference: floor division then clamp, argmax over the clamped values.
    function automatic exp_t model(input logic [N*AW-1:0] vec, input int acc_cyc);
        exp_t e;
        logic signed [AW-1:0] raw;
        int x, y, best, div;
        div = 1 << SH;
        e.data = '0;
        e.sat = 1'b0;
        e.amax = 0;
        e.acc_cycle = acc_cyc;
        best = 0;
        for (int i = 0; i < N; i++) begin
            raw = vec[i*AW +: AW];
            x = int'(raw);
            if (x >= 0) y = x / div;
            else y = -((-x + div - 1) / div);
            if (y > MAXV) begin y = MAXV; e.sat = 1'b1; end
            if (y < MINV) begin y = MINV; e.sat = 1'b1; end
            e.data[i*W +: W] = y[W-1:0];
            if (i == 0 || y > best) begin
                best = y;
                e.amax = i;
            end
        end
        return e;
    endfunction

    function automatic logic [N*AW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [N*AW-1:0] v;
        v[0*AW +: AW] = a[AW-1:0];
        v[1*AW +: AW] = b[AW-1:0];
        v[2*AW +: AW] = c[AW-1:0];
        v[3*AW +: AW] = d[AW-1:0];
        return v;
    endfunction

    function automatic logic [N*AW-1:0] randVec();
        logic [N*AW-1:0] v;
        int r;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 0) r = int'($urandom_range(0, 1200)) - 600;
            else r = int'($urandom_range(0, 65535)) - 32768;
            v[i*AW +: AW] = r[AW-1:0];
        end
        return v;
    endfunction

    // Offers a vector and pushes the model result at the cycle it is accepted.
    task automatic applyStimulus(input logic [N*AW-1:0] vec);
        bit accepted = 1'b0;
        @(negedge clk); #1;
        in_valid = 1'b1;
        neuron_in = vec;
        for (int t = 0; t < 100; t++) begin
            #1;
            if (in_ready) begin
                sb.push_back(model(vec, cycle + 1));
                accepted = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(negedge clk); #1;
        in_valid = 1'b0;
        neuron_in = randVec();
    endtask

    task automatic waitValid(input string name);
        bit seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk); #2;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput(name, 64'd0, 64'd1);
    endtask

    initial begin
        forever begin
            @(negedge clk); #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = ready_force;
            endcase
        end
    end

    initial begin
        exp_t e;
        bit prev_valid = 1'b0;
        forever begin
            @(negedge clk); #3;
            if (!rst_n) begin
                prev_valid = 1'b0;
                continue;
            end
            if (out_valid && !prev_valid && sb.size() > 0)
                checkOutput("latency", 64'(cycle - sb[0].acc_cycle), 64'(N));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_vector", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("data_out", 64'(data_out), 64'(e.data));
                    checkOutput("sat_flag", 64'(sat_flag), 64'(e.sat));
`ifdef ARGMAX_EN
                    checkOutput("argmax_idx", 64'(argmax_idx), 64'(e.amax));
`endif
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        logic [N*AW-1:0] vmix;
        exp_t emix;
        $display("[TB] start");
        vmix = pack4(100, -20, 1000, -1000);
        emix = model(vmix, 0);

        repeat (3) @(negedge clk);
        #2;
        checkOutput("in_ready_in_reset", 64'(in_ready), 64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_data_out", 64'(data_out), 64'd0);
        checkOutput("reset_sat_flag", 64'(sat_flag), 64'd0);
`ifdef ARGMAX_EN
        checkOutput("reset_argmax", 64'(argmax_idx), 64'd0);
`endif

        ready_mode = 0;
        applyStimulus(vmix);
        applyStimulus(pack4(40, 40, 8, -1));
        applyStimulus(pack4(-4, -8, -12, -400));
        repeat (8) @(negedge clk);

        $display("[TB] backpressure");
        ready_mode = 2;
        ready_force = 1'b0;
        applyStimulus(vmix);
        waitValid("bp_valid_timeout");
        for (int k = 0; k < 6; k++) begin
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_data_out", 64'(data_out), 64'(emix.data));
            checkOutput("bp_sat_flag", 64'(sat_flag), 64'd1);
            @(negedge clk); #2;
        end
        ready_force = 1'b1;
        @(negedge clk); #2;
        ready_force = 1'b0;
        @(negedge clk); #2;
        checkOutput("bp_single_xfer_valid", 64'(out_valid), 64'd0);
        checkOutput("bp_single_xfer_queue", 64'(sb.size()), 64'd0);

        $display("[TB] back-to-back");
        ready_mode = 0;
        applyStimulus(pack4(200, -300, 12, 7));
        applyStimulus(pack4(-5, 600, 600, 3));
        #1;
        checkOutput("b2b_valid_drop", 64'(out_valid), 64'd0);
        repeat (8) @(negedge clk);

        $display("[TB] reset mid-PROC");
        applyStimulus(pack4(900, 900, 900, 900));
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
        #1;
        checkOutput("rst_mid_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_mid_data_out", 64'(data_out), 64'd0);
        checkOutput("rst_mid_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_mid_sat_flag", 64'(sat_flag), 64'd0);
        repeat (10) @(negedge clk);

        $display("[TB] random traffic");
        ready_mode = 1;
        for (int v = 0; v < 30; v++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(randVec());
        end
        ready_mode = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); #4;
            if (sb.size() == 0 && !out_valid) break;
        end
        checkOutput("drain_queue", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
